peak_find: RTL and testbench
============================

# peak_find

Windowed peak search on the magnitude stream that follows the AMBM magnitude stage. After a `start` pulse, it scans exactly `WIN_LEN` valid magnitude samples and tracks the largest value and its index. It then reports the peak value, the peak index and a threshold-pass flag with a one-cycle `peak_valid` pulse. The timing-recovery control consumes this report as the coarse symbol/CP boundary estimate.

## Interface
Parameters:
- `WIN_LEN`, default 64: number of valid samples searched per window; must be ≥ 2.
- `IDX_W`, default `$clog2(WIN_LEN)`: width of the sample index.

Ports:
- `clk`, input, 1: single clock.
- `rst`, input, 1: reset. Synchronous, active-high.
- `start`, input, 1: begin a search window. Honoured only in IDLE.
- `thresh`, input, `MAG_W` (`mag_t`): detection threshold. Latched on an accepted `start`.
- `in_valid`, input, 1: `mag_in` is valid this cycle. Driven by the delay-matched valid of the magnitude stage, which has a 4-cycle latency.
- `mag_in`, input, `MAG_W` (`mag_t`): unsigned magnitude sample.
- `busy`, output, 1: high in SEARCH and REPORT.
- `peak_valid`, output, 1: one-cycle pulse; the result fields below are valid.
- `peak_idx`, output, `IDX_W`: index (0..`WIN_LEN`-1, counted in valid samples) of the peak.
- `peak_mag`, output, `MAG_W` (`mag_t`): peak magnitude.
- `peak_found`, output, 1: `peak_mag` ≥ latched threshold.

## Operation
- **FSM states:** IDLE, SEARCH, REPORT.
- **IDLE → SEARCH** on `start`=1.
  - Latch `thresh`.
  - Clear the sample counter `cnt`.
- **SEARCH:** every cycle with `in_valid`=1:
  - If `cnt`==0, or `mag_in` > `best_mag` (strict, unsigned), load `best_mag`←`mag_in` and `best_idx`←`cnt`.
  - Increment `cnt`.
  - `in_valid`=0 cycles are stalls: nothing changes and no timeout applies.
- **SEARCH → REPORT** on the cycle that accepts the sample with `cnt`==`WIN_LEN`-1.
- **REPORT:**
  - `peak_valid`=1 for exactly one cycle.
  - `peak_idx`/`peak_mag` carry the best-so-far value, including that final sample.
  - `peak_found` = (`peak_mag` ≥ latched threshold).
  - The next state is always IDLE.
- **Tie rule:** the earliest index wins because the comparison is strict. The first sample is always loaded, even if it is 0.
- **Comparison width:** `MAG_W`-bit unsigned. No arithmetic beyond the compare and the `IDX_W`-bit counter. `cnt` never wraps, because the window ends at `WIN_LEN`-1.
- **`start` outside IDLE** (SEARCH or REPORT) is ignored. It is not queued.
- **`start` and `in_valid` in the same IDLE cycle:** that sample is not counted. Counting begins the following cycle.
- **`in_valid` in IDLE or REPORT** is ignored.
- **Held outputs:** `peak_idx`, `peak_mag` and `peak_found` are registered and hold their last reported values until the next REPORT. Consumers qualify them with `peak_valid`.
- **Threshold:** a change of `thresh` during SEARCH has no effect on the current window.

## Timing
- **Reset values:**
  - FSM = IDLE.
  - `busy`=0, `peak_valid`=0, `peak_idx`=0, `peak_mag`=0, `peak_found`=0.
  - Internal `cnt`, `best_*` and latched threshold = 0.
- **`start` latency:** `start` sampled at edge t gives `busy`=1 from cycle t+1. The first countable sample is the one presented in cycle t+1.
- **Result latency:** the final sample accepted at edge k gives `peak_valid`=1 in cycle k+1, with `busy` still 1. In cycle k+2, `busy`=0, the FSM is in IDLE, and a new `start` can be accepted.
  - Minimum window period with no stalls: `WIN_LEN`+2 cycles, counting from the `start` cycle.
- **Reset mid-SEARCH or mid-REPORT:** state returns to IDLE on the next edge. No `peak_valid` is emitted for the aborted window, and all outputs take their reset values.

## Structure
- Use the shared `data_type` package for `mag_t` and `MAG_W`.
- Add `WIN_LEN_DEFAULT` and a `pf_state_t` enum (IDLE/SEARCH/REPORT) to the package, so the timing-recovery controller and the bench can decode the state.
- Implement as a single module with no sub-module. The datapath is one comparator plus a counter.

## Test plan
Bench uses `WIN_LEN`=8 and `MAG_W` from the package.
- **Single peak:** `thresh`=100, start, then samples 5,9,200,7,200,3,1,0 with no stalls → `peak_valid` exactly once, one cycle after the 8th sample; `peak_idx`=2, `peak_mag`=200, `peak_found`=1.
- **Stalls and below-threshold peak:** same window with random `in_valid` gaps, and `thresh`=250 → same idx/mag, `peak_found`=0, pulse one cycle after the last valid sample.
- **All zero:** samples all 0, `thresh`=0 → `peak_idx`=0, `peak_mag`=0, `peak_found`=1.
- **Peak at last index, start during SEARCH:** pulse `start` during SEARCH, and present peak 0x3FF at index 7 → `start` ignored, one report only, `peak_idx`=7; outputs hold until the next window's report.
- **Back-to-back:** `start` in the cycle right after `peak_valid` → accepted, second window reports independently; `start`+`in_valid` in the same IDLE cycle does not count that sample.
- **Reset mid-window:** assert `rst` after 4 samples → next cycle all outputs 0 and state IDLE; no `peak_valid` for the aborted window, and a fresh window then reports correctly.

Source files
------------

// File: rtl/data_type.sv
// Shared magnitude-stream types plus the peak-search state encoding, so the
// timing-recovery controller can decode the peak_find state.
package data_type;

  localparam int MAG_W = 16;
  typedef logic [MAG_W-1:0] mag_t;

  localparam int WIN_LEN_DEFAULT = 64;

  typedef enum logic [1:0] {
    PF_IDLE   = 2'd0,
    PF_SEARCH = 2'd1,
    PF_REPORT = 2'd2
  } pf_state_t;

endpackage

// File: rtl/peak_find.sv
// Windowed peak search: after start, scans WIN_LEN valid magnitude samples and
// reports the largest value, its index and a threshold-pass flag.
module peak_find
  import data_type::*;
#(
  parameter int WIN_LEN = WIN_LEN_DEFAULT,
  parameter int IDX_W   = $clog2(WIN_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MAG_W-1:0] thresh,
  input  logic             in_valid,
  input  logic [MAG_W-1:0] mag_in,
  output logic             busy,
  output logic             peak_valid,
  output logic [IDX_W-1:0] peak_idx,
  output logic [MAG_W-1:0] peak_mag,
  output logic             peak_found,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] ST_IDLE   = PF_IDLE;
  localparam logic [1:0] ST_SEARCH = PF_SEARCH;
  localparam logic [1:0] ST_REPORT = PF_REPORT;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

  // Handshake: a sample is consumed on any rising edge where in_valid=1 and the
  // FSM is in SEARCH; there is no backpressure, so in_valid=0 is simply a stall.

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  mag_t             best_mag_q, best_mag_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  mag_t             thresh_q, thresh_d;
  logic [IDX_W-1:0] peak_idx_q, peak_idx_d;
  mag_t             peak_mag_q, peak_mag_d;
  logic             peak_found_q, peak_found_d;

  logic accept;
  logic take;
  logic last;

  always_comb begin
    accept       = (state_q == ST_SEARCH) && in_valid;
    take         = accept && ((cnt_q == '0) || (mag_in > best_mag_q));
    last         = accept && (cnt_q == LAST_IDX);

    state_d      = state_q;
    cnt_d        = cnt_q;
    best_mag_d   = best_mag_q;
    best_idx_d   = best_idx_q;
    thresh_d     = thresh_q;
    peak_idx_d   = peak_idx_q;
    peak_mag_d   = peak_mag_q;
    peak_found_d = peak_found_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SEARCH;
          thresh_d = thresh;
          cnt_d    = '0;
        end
      end
      ST_SEARCH: begin
        if (take) begin
          best_mag_d = mag_in;
          best_idx_d = cnt_q;
        end
        if (accept) begin
          cnt_d = cnt_q + IDX_W'(1);
        end
        // The result registers capture the best including the final sample.
        if (last) begin
          state_d      = ST_REPORT;
          peak_idx_d   = best_idx_d;
          peak_mag_d   = best_mag_d;
          peak_found_d = (best_mag_d >= thresh_q);
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      best_mag_q   <= '0;
      best_idx_q   <= '0;
      thresh_q     <= '0;
      peak_idx_q   <= '0;
      peak_mag_q   <= '0;
      peak_found_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      best_mag_q   <= best_mag_d;
      best_idx_q   <= best_idx_d;
      thresh_q     <= thresh_d;
      peak_idx_q   <= peak_idx_d;
      peak_mag_q   <= peak_mag_d;
      peak_found_q <= peak_found_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign peak_valid = (state_q == ST_REPORT);
  assign peak_idx   = peak_idx_q;
  assign peak_mag   = peak_mag_q;
  assign peak_found = peak_found_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_peak_find.sv
// Directed bench for peak_find with an 8-sample window.
module tb_peak_find;
  import data_type::*;

  localparam int WL = 8;
  localparam int IW = 3;
  localparam int EW = 1 + IW + MAG_W;

  logic          clk;
  logic          rst;
  logic          start;
  mag_t          thresh;
  logic          in_valid;
  mag_t          mag_in;
  logic          busy;
  logic          peak_valid;
  logic [IW-1:0] peak_idx;
  mag_t          peak_mag;
  logic          peak_found;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;

  logic [EW-1:0] exp_q[$];
  mag_t          smp[WL];

  peak_find #(.WIN_LEN(WL)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .thresh    (thresh),
    .in_valid  (in_valid),
    .mag_in    (mag_in),
    .busy      (busy),
    .peak_valid(peak_valid),
    .peak_idx  (peak_idx),
    .peak_mag  (peak_mag),
    .peak_found(peak_found),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pv"}, 32'(peak_valid), 32'd0);
    chk({tag, "_idx"}, 32'(peak_idx), 32'd0);
    chk({tag, "_mag"}, 32'(peak_mag), 32'd0);
    chk({tag, "_found"}, 32'(peak_found), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(PF_IDLE));
  endtask

  // driver: start a window, optionally with a simultaneous (uncounted) sample
  task automatic start_win(input mag_t th, input logic with_sample, input mag_t stray);
    start    = 1'b1;
    thresh   = th;
    in_valid = with_sample;
    mag_in   = stray;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    thresh   = ~th;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_state", 32'(dbg_state), 32'(PF_SEARCH));
  endtask

  // driver: feed smp[], with up to max_gap stall cycles before each sample;
  // optional stray start pulse alongside sample start_at (ignored by the DUT)
  task automatic feed_window(input int max_gap, input int start_at);
    logic [EW-1:0] e;
    for (int i = 0; i < WL; i++) begin
      int gap;
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("stall_pv", 32'(peak_valid), 32'd0);
      end
      in_valid = 1'b1;
      mag_in   = smp[i];
      start    = (i == start_at);
      tick();
      in_valid = 1'b0;
      start    = 1'b0;
      if (i < WL - 1) chk("early_pv", 32'(peak_valid), 32'd0);
    end
    // scoreboard compare against the hand-computed expectation
    chk("report_pv", 32'(peak_valid), 32'd1);
    chk("report_busy", 32'(busy), 32'd1);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty observed=empty expected=entry");
    end else begin
      e = exp_q.pop_front();
      chk("report_found", 32'(peak_found), 32'(e[EW-1]));
      chk("report_idx", 32'(peak_idx), 32'(e[EW-2 -: IW]));
      chk("report_mag", 32'(peak_mag), 32'(e[MAG_W-1:0]));
    end
    tick();
    chk("post_pv", 32'(peak_valid), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_state", 32'(dbg_state), 32'(PF_IDLE));
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    thresh   = '0;
    in_valid = 1'b0;
    mag_in   = '0;
    tick();
    tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();
    chk_reset_vals("idle_after_reset");

    // in_valid while idle is ignored
    in_valid = 1'b1;
    mag_in   = 16'd77;
    tick();
    in_valid = 1'b0;
    chk("idle_valid_state", 32'(dbg_state), 32'(PF_IDLE));

    // single peak, tie at index 4 loses to index 2
    smp = '{16'd5, 16'd9, 16'd200, 16'd7, 16'd200, 16'd3, 16'd1, 16'd0};
    exp_q.push_back({1'b1, 3'd2, 16'd200});
    start_win(16'd100, 1'b0, '0);
    feed_window(0, -1);

    // stalls, peak below threshold
    exp_q.push_back({1'b0, 3'd2, 16'd200});
    start_win(16'd250, 1'b0, '0);
    feed_window(3, -1);

    // all zero, threshold 0: first sample loaded, found by >=
    smp = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    exp_q.push_back({1'b1, 3'd0, 16'd0});
    start_win(16'd0, 1'b0, '0);
    feed_window(1, -1);

    // peak at last index, stray start during SEARCH
    smp = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'h03FF};
    exp_q.push_back({1'b1, 3'd7, 16'h03FF});
    start_win(16'h0200, 1'b0, '0);
    feed_window(0, 3);
    for (int k = 0; k < 3; k++) tick();
    chk("hold_idx", 32'(peak_idx), 32'd7);
    chk("hold_mag", 32'(peak_mag), 32'h3FF);
    chk("hold_state", 32'(dbg_state), 32'(PF_IDLE));

    // back-to-back, stray sample with start must not count
    smp = '{16'd50, 16'd40, 16'd30, 16'd80, 16'd80, 16'd10, 16'd20, 16'd5};
    exp_q.push_back({1'b1, 3'd3, 16'd80});
    start_win(16'd60, 1'b1, 16'h03FE);
    chk("b2b_hold_idx", 32'(peak_idx), 32'd7);
    feed_window(0, -1);
    smp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    exp_q.push_back({1'b0, 3'd7, 16'd8});
    start_win(16'd9, 1'b0, '0);
    feed_window(0, -1);

    // reset mid-window aborts without a report
    start_win(16'd0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      mag_in   = 16'd500;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("mid_reset");
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("aborted_pv", 32'(peak_valid), 32'd0);
    end
    smp = '{16'd3, 16'd1, 16'd4, 16'd1, 16'd5, 16'd9, 16'd2, 16'd6};
    exp_q.push_back({1'b1, 3'd5, 16'd9});
    start_win(16'd9, 1'b0, '0);
    feed_window(2, -1);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
